// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: single-cycle arithmetic/logic ops, bit-serial shifts,
// valid/ready handshakes on both sides and registered Z/C/N flags.
module alu_exec_unit #(
   parameter int W   = 8,
   parameter int SHW = $clog2(W)
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   in_op,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_result,
   output logic         out_wr_en,
   output logic         flag_z,
   output logic         flag_c,
   output logic         flag_n,
   output logic         busy
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_LSL = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_CMP = 3'b100;
   localparam logic [2:0] OP_SET = 3'b101;
   localparam logic [2:0] OP_LSR = 3'b110;
   localparam logic [2:0] OP_SUB = 3'b111;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   state_t         r_state;
   logic [W-1:0]   r_work;
   logic [SHW-1:0] r_cnt;
   logic           r_left;

   logic [W:0]     w_sum;
   logic [W-1:0]   w_diff;
   logic [SHW-1:0] w_shamt;
   logic           w_is_shift;
   logic [W-1:0]   w_res;
   logic [W-1:0]   w_fval;
   logic           w_c;
   logic           w_wr;
   logic           w_upd;
   logic [W-1:0]   w_step;
   logic           w_out;

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign busy      = (r_state != ST_IDLE);

   assign w_shamt    = in_b[SHW-1:0];
   assign w_is_shift = (in_op == OP_LSL) || (in_op == OP_LSR);

   // Single-cycle result; also covers zero-amount shifts, which pass in_a through.
   always_comb begin
      w_sum  = {1'b0, in_a} + {1'b0, in_b};
      w_diff = in_a - in_b;
      w_res  = '0;
      w_fval = '0;
      w_c    = 1'b0;
      w_wr   = 1'b1;
      w_upd  = 1'b1;
      case (in_op)
         OP_ADD: begin
            w_res  = w_sum[W-1:0];
            w_c    = w_sum[W];
            w_fval = w_sum[W-1:0];
         end
         OP_LSL, OP_LSR: begin
            w_res  = in_a;
            w_fval = in_a;
         end
         OP_XOR: begin
            w_res  = in_a ^ in_b;
            w_fval = in_a ^ in_b;
         end
         OP_AND: begin
            w_res  = in_a & in_b;
            w_fval = in_a & in_b;
         end
         OP_CMP: begin
            w_res  = in_a;
            w_c    = (in_a >= in_b);
            w_fval = w_diff;
            w_wr   = 1'b0;
         end
         OP_SET: begin
            w_res  = in_b;
            w_upd  = 1'b0;
         end
         default: begin
            w_res  = w_diff;
            w_c    = (in_a >= in_b);
            w_fval = w_diff;
         end
      endcase
   end

   always_comb begin
      if (r_left) begin
         w_step = {r_work[W-2:0], 1'b0};
         w_out  = r_work[W-1];
      end else begin
         w_step = {1'b0, r_work[W-1:1]};
         w_out  = r_work[0];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state    <= ST_IDLE;
         r_work     <= '0;
         r_cnt      <= '0;
         r_left     <= 1'b0;
         out_result <= '0;
         out_wr_en  <= 1'b0;
         flag_z     <= 1'b0;
         flag_c     <= 1'b0;
         flag_n     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (w_is_shift && (w_shamt != '0)) begin
                     r_work  <= in_a;
                     r_cnt   <= w_shamt;
                     r_left  <= (in_op == OP_LSL);
                     r_state <= ST_SHIFT;
                  end else begin
                     out_result <= w_res;
                     out_wr_en  <= w_wr;
                     if (w_upd) begin
                        flag_z <= (w_fval == '0);
                        flag_c <= w_c;
                        flag_n <= w_fval[W-1];
                     end
                     r_state <= ST_DONE;
                  end
               end
            end
            // Last shift step writes the outputs directly so out_valid rises n+1 cycles after accept.
            ST_SHIFT: begin
               r_work <= w_step;
               r_cnt  <= r_cnt - SHW'(1);
               if (r_cnt == SHW'(1)) begin
                  out_result <= w_step;
                  out_wr_en  <= 1'b1;
                  flag_z     <= (w_step == '0);
                  flag_c     <= w_out;
                  flag_n     <= w_step[W-1];
                  r_state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors checked with immediate assertions.
module tb_alu_exec_unit;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic       out_wr_en;
   logic       flag_z;
   logic       flag_c;
   logic       flag_n;
   logic       busy;

   int n_chk  = 0;
   int n_fail = 0;

   alu_exec_unit #(.W(8)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_wr_en(out_wr_en),
      .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .busy(busy)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Present one op in IDLE, then wait (bounded) for out_valid; lat counts cycles from accept.
   task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic rdy_low);
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat      = 1;
      rdy_low  = ~in_ready;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
         if (in_ready) rdy_low = 1'b0;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   int   lat;
   logic rlow;

   initial begin
      Reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_op     = 3'd0;
      in_a      = 8'd0;
      in_b      = 8'd0;
      #12;
      chk("rst_outv", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_res", {24'd0, out_result}, 32'h00);
      chk("rst_zcn_wr", {28'd0, flag_z, flag_c, flag_n, out_wr_en}, 32'h0);
      Reset_n = 1'b1;
      tick();

      // ADD 0xF0+0x20 = 0x110
      do_op(3'b000, 8'hF0, 8'h20, lat, rlow);
      chk("add_lat", lat, 1);
      chk("add_res", {24'd0, out_result}, 32'h10);
      chk("add_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b010);
      chk("add_wr", {31'd0, out_wr_en}, 32'd1);
      release_out();
      chk("add_drop", {31'd0, out_valid}, 32'd0);

      do_op(3'b111, 8'h05, 8'h05, lat, rlow);
      chk("sub_res", {24'd0, out_result}, 32'h00);
      chk("sub_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b110);
      release_out();

      do_op(3'b100, 8'h03, 8'h07, lat, rlow);
      chk("cmp_res", {24'd0, out_result}, 32'h03);
      chk("cmp_wr", {31'd0, out_wr_en}, 32'd0);
      chk("cmp_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b001);
      release_out();

      do_op(3'b001, 8'h81, 8'h03, lat, rlow);
      chk("lsl_lat", lat, 4);
      chk("lsl_rdy_low", {31'd0, rlow}, 32'd1);
      chk("lsl_res", {24'd0, out_result}, 32'h08);
      chk("lsl_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b000);
      chk("lsl_wr", {31'd0, out_wr_en}, 32'd1);
      release_out();

      do_op(3'b110, 8'h81, 8'h01, lat, rlow);
      chk("lsr_lat", lat, 2);
      chk("lsr_res", {24'd0, out_result}, 32'h40);
      chk("lsr_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b010);
      release_out();

      // SET keeps the LSR flags (C=1)
      do_op(3'b101, 8'h00, 8'h5A, lat, rlow);
      chk("set_res", {24'd0, out_result}, 32'h5A);
      chk("set_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b010);
      chk("set_wr", {31'd0, out_wr_en}, 32'd1);
      release_out();

      // Shift amount uses only low 3 bits: 0x08 -> 0
      do_op(3'b001, 8'h3C, 8'h08, lat, rlow);
      chk("lsl0_lat", lat, 1);
      chk("lsl0_res", {24'd0, out_result}, 32'h3C);
      chk("lsl0_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b000);
      release_out();

      do_op(3'b010, 8'hAA, 8'hAA, lat, rlow);
      chk("xor_res", {24'd0, out_result}, 32'h00);
      chk("xor_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b100);
      release_out();

      do_op(3'b011, 8'hF0, 8'h8F, lat, rlow);
      chk("and_res", {24'd0, out_result}, 32'h80);
      chk("and_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b001);
      release_out();

      // Backpressure: result held while a new op waits on the input
      do_op(3'b000, 8'h01, 8'h02, lat, rlow);
      chk("bp_first", {24'd0, out_result}, 32'h03);
      in_op    = 3'b000;
      in_a     = 8'h10;
      in_b     = 8'h20;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_v", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_res", {24'd0, out_result}, 32'h03);
         chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_handoff_v", {31'd0, out_valid}, 32'd0);
      chk("bp_handoff_rdy", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_second_v", {31'd0, out_valid}, 32'd1);
      chk("bp_second_res", {24'd0, out_result}, 32'h30);
      release_out();

      // Set nonzero flags, then abort an LSL by 5 in its second cycle
      do_op(3'b000, 8'hFF, 8'h81, lat, rlow);
      chk("pre_rst_res", {24'd0, out_result}, 32'h80);
      chk("pre_rst_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b011);
      release_out();
      in_op    = 3'b001;
      in_a     = 8'h01;
      in_b     = 8'h05;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("mid_busy", {31'd0, busy}, 32'd1);
      tick();
      #2;
      Reset_n = 1'b0;
      #1;
      chk("abort_outv", {31'd0, out_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b000);
      chk("abort_res", {24'd0, out_result}, 32'h00);
      #2;
      Reset_n = 1'b1;
      tick();
      do_op(3'b110, 8'h80, 8'h07, lat, rlow);
      chk("post_lat", lat, 8);
      chk("post_res", {24'd0, out_result}, 32'h01);
      chk("post_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b000);
      release_out();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
